idu_inst_buffer: RTL and testbench

- Instruction buffer at the IFU→IDU boundary.
- Accepts up to two fetched instructions per cycle (instruction, PC, unaligned-PC flag) into a circular FIFO.
- Presents the two oldest entries to the dispatcher; the dispatcher retires 0, 1 or 2 entries per cycle.
- Back-pressures the IFU with a full flag; contents are discarded on a branch flush or on an exception/WFI detection.

---
 rtl/idu_inst_buffer.sv | 195 +++++++++++++++++++
 tb/tb_idu_inst_buffer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/idu_inst_buffer.sv
// ---------------------------------------------------------------------------
// idu_inst_buffer
//   Instruction buffer between the fetch unit and the decode/dispatch stage.
//   Two-wide circular FIFO: up to two fetched instructions (inst, pc,
//   unaligned flag) are written per cycle, and the two oldest entries are
//   presented to the dispatcher, which retires 0, 1 or 2 per cycle.
//   A branch flush or exception/WFI detection empties the buffer.
//
//   Optional build macro: INSTBUF_OUT_ZERO_EN
//     defined   -> data outputs of a slot read as 0 while that slot is invalid
//     undefined -> data outputs always show the raw entry contents
// ---------------------------------------------------------------------------
module idu_inst_buffer #(
  parameter int INST_WIDTH = 32,
  parameter int PC_WIDTH   = 32,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  ifu_idu_fetch_vld,
  output logic                  idu_ifu_instBuffer_full,

  input  logic                  dispatch_vld_0,
  input  logic                  dispatch_vld_1,
  input  logic                  dispatcher_detect_exceptions_wfi,
  input  logic                  bru_flush,

  output logic                  instBuffer_inst_vld_0,
  output logic                  instBuffer_inst_vld_1,

  input  logic [INST_WIDTH-1:0] inst_in_0,
  input  logic [INST_WIDTH-1:0] inst_in_1,
  input  logic [PC_WIDTH-1:0]   pc_in_0,
  input  logic [PC_WIDTH-1:0]   pc_in_1,
  input  logic                  unalign_pc_in_0,
  input  logic                  unalign_pc_in_1,

  output logic [INST_WIDTH-1:0] inst_out_0,
  output logic [INST_WIDTH-1:0] inst_out_1,
  output logic [PC_WIDTH-1:0]   pc_out_0,
  output logic [PC_WIDTH-1:0]   pc_out_1,
  output logic                  unalign_pc_out_0,
  output logic                  unalign_pc_out_1
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_TWO   = CW'(2);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [PW-1:0] PTR_TWO   = PW'(2);

  // Storage and pointers
  logic [INST_WIDTH-1:0] inst_q    [DEPTH];
  logic [INST_WIDTH-1:0] inst_d    [DEPTH];
  logic [PC_WIDTH-1:0]   pc_q      [DEPTH];
  logic [PC_WIDTH-1:0]   pc_d      [DEPTH];
  logic                  unalign_q [DEPTH];
  logic                  unalign_d [DEPTH];

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q,  cnt_d;

  logic          full;
  logic          wr;
  logic          clear;
  logic [1:0]    ndisp_raw;
  logic [1:0]    ndisp;
  logic [PW-1:0] wptr_p1;
  logic [PW-1:0] rptr_p1;

  // Full when fewer than two entries remain free (registered count only)
  always_comb begin
    full = (CNT_DEPTH - cnt_q) < CNT_TWO;
  end

  // Write enable, dispatch amount and clear qualification
  always_comb begin
    clear   = bru_flush | dispatcher_detect_exceptions_wfi;
    wr      = ifu_idu_fetch_vld & ~full;
    wptr_p1 = wptr_q + PTR_ONE;
    rptr_p1 = rptr_q + PTR_ONE;

    // dispatch_vld_1 on its own retires nothing
    if (dispatch_vld_0)
      ndisp_raw = dispatch_vld_1 ? 2'd2 : 2'd1;
    else
      ndisp_raw = 2'd0;

    // Never retire more than is held; same-cycle writes are not visible yet
    if (cnt_q == '0)
      ndisp = 2'd0;
    else if ((cnt_q == CW'(1)) && (ndisp_raw == 2'd2))
      ndisp = 2'd1;
    else
      ndisp = ndisp_raw;
  end

  // Next-state for pointers and occupancy; clear overrides write and dispatch
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (clear) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (wr)
        wptr_d = wptr_q + PTR_TWO;
      rptr_d = rptr_q + PW'(ndisp);
      cnt_d  = cnt_q + (wr ? CNT_TWO : '0) - CW'(ndisp);
    end
  end

  // Next-state for entry storage: two consecutive slots per accepted fetch
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      inst_d[i]    = inst_q[i];
      pc_d[i]      = pc_q[i];
      unalign_d[i] = unalign_q[i];
    end
    if (wr && !clear) begin
      inst_d[wptr_q]     = inst_in_0;
      pc_d[wptr_q]       = pc_in_0;
      unalign_d[wptr_q]  = unalign_pc_in_0;
      inst_d[wptr_p1]    = inst_in_1;
      pc_d[wptr_p1]      = pc_in_1;
      unalign_d[wptr_p1] = unalign_pc_in_1;
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Entry storage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        inst_q[i]    <= '0;
        pc_q[i]      <= '0;
        unalign_q[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        inst_q[i]    <= inst_d[i];
        pc_q[i]      <= pc_d[i];
        unalign_q[i] <= unalign_d[i];
      end
    end
  end

  // Output slots decoded from registered state; no input-to-output bypass
  always_comb begin
    idu_ifu_instBuffer_full = full;
    instBuffer_inst_vld_0   = (cnt_q >= CW'(1));
    instBuffer_inst_vld_1   = (cnt_q >= CNT_TWO);

    inst_out_0       = inst_q[rptr_q];
    pc_out_0         = pc_q[rptr_q];
    unalign_pc_out_0 = unalign_q[rptr_q];
    inst_out_1       = inst_q[rptr_p1];
    pc_out_1         = pc_q[rptr_p1];
    unalign_pc_out_1 = unalign_q[rptr_p1];

`ifdef INSTBUF_OUT_ZERO_EN
    if (!instBuffer_inst_vld_0) begin
      inst_out_0       = '0;
      pc_out_0         = '0;
      unalign_pc_out_0 = 1'b0;
    end
    if (!instBuffer_inst_vld_1) begin
      inst_out_1       = '0;
      pc_out_1         = '0;
      unalign_pc_out_1 = 1'b0;
    end
`else
    // Raw entry contents are presented regardless of the valid flags
`endif
  end

endmodule

// File: tb/tb_idu_inst_buffer.sv
// Directed self-checking bench for idu_inst_buffer (default build).
module tb_idu_inst_buffer;

  logic        clk;
  logic        rst_n;
  logic        ifu_idu_fetch_vld;
  logic        idu_ifu_instBuffer_full;
  logic        dispatch_vld_0;
  logic        dispatch_vld_1;
  logic        dispatcher_detect_exceptions_wfi;
  logic        bru_flush;
  logic        instBuffer_inst_vld_0;
  logic        instBuffer_inst_vld_1;
  logic [31:0] inst_in_0, inst_in_1;
  logic [31:0] pc_in_0, pc_in_1;
  logic        unalign_pc_in_0, unalign_pc_in_1;
  logic [31:0] inst_out_0, inst_out_1;
  logic [31:0] pc_out_0, pc_out_1;
  logic        unalign_pc_out_0, unalign_pc_out_1;

  int checks;
  int failures;

  idu_inst_buffer #(.INST_WIDTH(32), .PC_WIDTH(32), .DEPTH(8)) dut (
    .clk                              (clk),
    .rst_n                            (rst_n),
    .ifu_idu_fetch_vld                (ifu_idu_fetch_vld),
    .idu_ifu_instBuffer_full          (idu_ifu_instBuffer_full),
    .dispatch_vld_0                   (dispatch_vld_0),
    .dispatch_vld_1                   (dispatch_vld_1),
    .dispatcher_detect_exceptions_wfi (dispatcher_detect_exceptions_wfi),
    .bru_flush                        (bru_flush),
    .instBuffer_inst_vld_0            (instBuffer_inst_vld_0),
    .instBuffer_inst_vld_1            (instBuffer_inst_vld_1),
    .inst_in_0                        (inst_in_0),
    .inst_in_1                        (inst_in_1),
    .pc_in_0                          (pc_in_0),
    .pc_in_1                          (pc_in_1),
    .unalign_pc_in_0                  (unalign_pc_in_0),
    .unalign_pc_in_1                  (unalign_pc_in_1),
    .inst_out_0                       (inst_out_0),
    .inst_out_1                       (inst_out_1),
    .pc_out_0                         (pc_out_0),
    .pc_out_1                         (pc_out_1),
    .unalign_pc_out_0                 (unalign_pc_out_0),
    .unalign_pc_out_1                 (unalign_pc_out_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle away from it
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pair(input logic vld, input logic [31:0] i0, input logic [31:0] i1,
                          input logic [31:0] p0, input logic [31:0] p1, input logic u);
    ifu_idu_fetch_vld = vld;
    inst_in_0 = i0;  inst_in_1 = i1;
    pc_in_0   = p0;  pc_in_1   = p1;
    unalign_pc_in_0 = u;  unalign_pc_in_1 = u;
  endtask

  task automatic set_disp(input logic d1, input logic d0);
    dispatch_vld_1 = d1;
    dispatch_vld_0 = d0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bru_flush = 1'b0;
    dispatcher_detect_exceptions_wfi = 1'b0;
    set_disp(1'b0, 1'b0);
    set_pair(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);

    // Reset state (sampled while reset is held)
    #12;
    chk("rst_full", 32'(idu_ifu_instBuffer_full), 32'd0);
    chk("rst_vld0", 32'(instBuffer_inst_vld_0), 32'd0);
    chk("rst_vld1", 32'(instBuffer_inst_vld_1), 32'd0);
    chk("rst_inst0", inst_out_0, 32'd0);
    chk("rst_pc1", pc_out_1, 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("post_rst_vld0", 32'(instBuffer_inst_vld_0), 32'd0);

    // Fill with four pairs
    for (int k = 0; k < 4; k++) begin
      set_pair(1'b1, 32'(2*k), 32'(2*k+1), 32'h1000 + 32'(2*k), 32'h1000 + 32'(2*k+1), 1'(k % 2));
      cyc();
      if (k == 0) begin
        chk("fill1_vld1", 32'(instBuffer_inst_vld_1), 32'd1);
        chk("fill1_inst1", inst_out_1, 32'd1);
      end
      if (k == 2) chk("fill3_full_cnt6", 32'(idu_ifu_instBuffer_full), 32'd0);
    end
    chk("fill_full", 32'(idu_ifu_instBuffer_full), 32'd1);
    chk("fill_vld0", 32'(instBuffer_inst_vld_0), 32'd1);
    chk("fill_vld1", 32'(instBuffer_inst_vld_1), 32'd1);
    chk("fill_inst0", inst_out_0, 32'd0);
    chk("fill_inst1", inst_out_1, 32'd1);
    chk("fill_pc0", pc_out_0, 32'h1000);
    chk("fill_un0", 32'(unalign_pc_out_0), 32'd0);
    chk("fill_un1", 32'(unalign_pc_out_1), 32'd0);

    // Fetch while full: dropped
    set_pair(1'b1, 32'd8, 32'd9, 32'h1008, 32'h1009, 1'b0);
    cyc();
    chk("drop_full", 32'(idu_ifu_instBuffer_full), 32'd1);
    chk("drop_inst0", inst_out_0, 32'd0);

    // Dispatch one (cnt 8 -> 7, still full)
    set_pair(1'b0, 32'd8, 32'd9, 32'h1008, 32'h1009, 1'b0);
    set_disp(1'b0, 1'b1);
    cyc();
    chk("d1_full", 32'(idu_ifu_instBuffer_full), 32'd1);
    chk("d1_inst0", inst_out_0, 32'd1);
    chk("d1_inst1", inst_out_1, 32'd2);

    // Dispatch two (cnt 7 -> 5, not full)
    set_disp(1'b1, 1'b1);
    cyc();
    chk("d2_full", 32'(idu_ifu_instBuffer_full), 32'd0);
    chk("d2_inst0", inst_out_0, 32'd3);
    chk("d2_un0", 32'(unalign_pc_out_0), 32'd1);
    chk("d2_inst1", inst_out_1, 32'd4);
    chk("d2_un1", 32'(unalign_pc_out_1), 32'd0);

    // Drain 5 -> 3 -> 1, then dispatch-two on a single entry clamps to one
    cyc();
    chk("drain3_inst0", inst_out_0, 32'd5);
    cyc();
    chk("drain1_vld0", 32'(instBuffer_inst_vld_0), 32'd1);
    chk("drain1_vld1", 32'(instBuffer_inst_vld_1), 32'd0);
    chk("drain1_inst0", inst_out_0, 32'd7);
    cyc();
    chk("clamp_vld0", 32'(instBuffer_inst_vld_0), 32'd0);
    cyc();
    chk("empty_disp_vld0", 32'(instBuffer_inst_vld_0), 32'd0);
    chk("empty_disp_full", 32'(idu_ifu_instBuffer_full), 32'd0);

    // Write after clamped drain: exactly two entries, in order
    set_disp(1'b0, 1'b0);
    set_pair(1'b1, 32'd20, 32'd21, 32'h2020, 32'h2021, 1'b1);
    cyc();
    set_pair(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    chk("refill_vld0", 32'(instBuffer_inst_vld_0), 32'd1);
    chk("refill_vld1", 32'(instBuffer_inst_vld_1), 32'd1);
    chk("refill_inst0", inst_out_0, 32'd20);
    chk("refill_inst1", inst_out_1, 32'd21);
    set_disp(1'b1, 1'b1);
    cyc();
    set_disp(1'b0, 1'b0);
    chk("refill_drain_vld0", 32'(instBuffer_inst_vld_0), 32'd0);

    // Flush with concurrent fetch: nothing written
    set_pair(1'b1, 32'd30, 32'd31, 32'h3030, 32'h3031, 1'b0);
    bru_flush = 1'b1;
    cyc();
    bru_flush = 1'b0;
    set_pair(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    chk("flush_vld0", 32'(instBuffer_inst_vld_0), 32'd0);
    chk("flush_vld1", 32'(instBuffer_inst_vld_1), 32'd0);
    chk("flush_full", 32'(idu_ifu_instBuffer_full), 32'd0);

    // Refill one pair; pointers restart at 0
    set_pair(1'b1, 32'd40, 32'd41, 32'h4040, 32'h4041, 1'b0);
    cyc();
    set_pair(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    chk("postflush_inst0", inst_out_0, 32'd40);
    chk("postflush_pc1", pc_out_1, 32'h4041);

    // Exception/WFI clear, with a dispatch request also pending
    dispatcher_detect_exceptions_wfi = 1'b1;
    set_disp(1'b1, 1'b1);
    cyc();
    dispatcher_detect_exceptions_wfi = 1'b0;
    set_disp(1'b0, 1'b0);
    chk("exc_vld0", 32'(instBuffer_inst_vld_0), 32'd0);
    chk("exc_vld1", 32'(instBuffer_inst_vld_1), 32'd0);
    chk("exc_full", 32'(idu_ifu_instBuffer_full), 32'd0);

    // Pointer wrap: prime one pair, then write-2/dispatch-2 concurrently
    set_pair(1'b1, 32'd100, 32'd101, 32'h5000, 32'h5004, 1'b0);
    cyc();
    set_disp(1'b1, 1'b1);
    for (int j = 0; j < 10; j++) begin
      set_pair(1'b1, 32'(102 + 2*j), 32'(103 + 2*j),
               32'h5000 + 32'(4*(2 + 2*j)), 32'h5000 + 32'(4*(3 + 2*j)), 1'b0);
      cyc();
      chk($sformatf("wrap%0d_pc0", j), pc_out_0, 32'h5000 + 32'(4*(2 + 2*j)));
      chk($sformatf("wrap%0d_pc1", j), pc_out_1, 32'h5000 + 32'(4*(3 + 2*j)));
      chk($sformatf("wrap%0d_vld1", j), 32'(instBuffer_inst_vld_1), 32'd1);
    end
    chk("wrap_full", 32'(idu_ifu_instBuffer_full), 32'd0);

    // dispatch_vld_1 alone consumes nothing
    set_pair(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    set_disp(1'b1, 1'b0);
    cyc();
    set_disp(1'b0, 1'b0);
    chk("d10_pc0", pc_out_0, 32'h5000 + 32'(4*20));
    chk("d10_inst1", inst_out_1, 32'd121);
    chk("d10_vld1", 32'(instBuffer_inst_vld_1), 32'd1);

    // Asynchronous reset mid-cycle empties the buffer
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_vld0", 32'(instBuffer_inst_vld_0), 32'd0);
    chk("async_rst_pc0", pc_out_0, 32'd0);
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
